// File: rtl/jtsdram_bank_resp.sv
// Single-bank SDRAM responder. It is the target side of the bank request interface
// and serves reads and writes from an internal 16-bit block RAM. Accesses see
// SDRAM-like latency, and the bank stalls periodically for refresh.
//
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   ba_addr      : word address; only the low MW bits index the store
//   ba_rd, ba_wr : requests, held until ba_ack (a write wins when both are set)
//   ba_din       : write data
//   ba_din_m     : byte mask; a set bit keeps that byte unchanged
//   refresh_en   : enables the periodic refresh stalls
//   ba_ack       : one-cycle pulse when a request is accepted
//   ba_dst       : one-cycle pulse when read data starts
//   ba_dok       : high during the two read data cycles
//   ba_rdy       : one-cycle pulse when an access completes
//   data_read    : {mem[idx+1], mem[idx]} from the last completed read
//   busy         : high whenever the bank is not idle
module jtsdram_bank_resp #(
  parameter int unsigned AW         = 22,
  parameter int unsigned MW         = 10,
  parameter int unsigned CL         = 2,
  parameter int unsigned REF_PERIOD = 384,
  parameter int unsigned REF_LEN    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ba_addr,
  input  logic          ba_rd,
  input  logic          ba_wr,
  input  logic [15:0]   ba_din,
  input  logic [1:0]    ba_din_m,
  input  logic          refresh_en,
  output logic          ba_ack,
  output logic          ba_dst,
  output logic          ba_dok,
  output logic          ba_rdy,
  output logic [31:0]   data_read,
  output logic          busy
);

  localparam int unsigned Depth = 1 << MW;
  // Shared phase counter covers WAIT (up to CL-1 <= 6), DATA, WDONE and REF_LEN.
  localparam int unsigned CntW  = $clog2(REF_LEN + 8);
  localparam int unsigned RefW  = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

  typedef enum logic [2:0] {StIdle, StRefresh, StWait, StData, StDone, StWdone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic            ref_pend_q, ref_pend_d;
  logic [MW-1:0]   idx_q, idx_d;
  logic [15:0]     din_q, din_d;
  logic [1:0]      mask_q, mask_d;
  logic [15:0]     word0_q, word0_d;
  logic [31:0]     data_read_q, data_read_d;
  logic            ack_q, ack_d;
  logic            dst_q, dst_d;
  logic            dok_q, dok_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            ref_clr;

  logic [15:0]     mem [Depth];
  logic [15:0]     mem_q;
  logic [MW-1:0]   rd_idx;
  logic            mem_we;

  // Upper address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^ba_addr[AW-1:MW];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    din_d       = din_q;
    mask_d      = mask_q;
    word0_d     = word0_q;
    data_read_d = data_read_q;
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q;
    ref_clr     = 1'b0;
    ack_d       = 1'b0;
    dst_d       = 1'b0;
    rdy_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ref_pend_q) begin
          state_d = StRefresh;
          cnt_d   = '0;
          ref_clr = 1'b1;
        end else if (ba_wr) begin
          state_d = StWdone;
          cnt_d   = '0;
          idx_d   = ba_addr[MW-1:0];
          din_d   = ba_din;
          mask_d  = ba_din_m;
          ack_d   = 1'b1;
        end else if (ba_rd) begin
          state_d = StWait;
          cnt_d   = '0;
          idx_d   = ba_addr[MW-1:0];
          ack_d   = 1'b1;
        end
      end
      StRefresh: begin
        if (cnt_q == CntW'(REF_LEN - 1)) state_d = StIdle;
        else cnt_d = cnt_q + CntW'(1);
      end
      // The ack cycle is the first WAIT cycle, so WAIT lasts CL cycles in total.
      StWait: begin
        if (cnt_q == CntW'(CL - 1)) begin
          state_d = StData;
          cnt_d   = '0;
          dst_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(1);
          word0_d = mem_q;
        end else begin
          state_d     = StDone;
          data_read_d = {mem_q, word0_q};
          rdy_d       = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      // Phase 0 is the ack cycle (memory written at its closing edge), phase 1 is ba_rdy.
      StWdone: begin
        if (cnt_q == '0) begin
          cnt_d = CntW'(1);
          rdy_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!refresh_en) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b0;
    end else begin
      if (ref_clr) ref_pend_d = 1'b0;
      if (ref_cnt_q == RefW'(REF_PERIOD - 1)) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + RefW'(1);
      end
    end

    dok_d  = (state_d == StData);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      idx_q       <= '0;
      din_q       <= '0;
      mask_q      <= '0;
      word0_q     <= '0;
      data_read_q <= '0;
      ack_q       <= 1'b0;
      dst_q       <= 1'b0;
      dok_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      idx_q       <= idx_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      word0_q     <= word0_d;
      data_read_q <= data_read_d;
      ack_q       <= ack_d;
      dst_q       <= dst_d;
      dok_q       <= dok_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  // Synchronous-read port: the address for word0 is presented in the last WAIT
  // cycle and the address for word1 in the first DATA cycle.
  assign rd_idx = (state_q == StData) ? idx_q + MW'(1) : idx_q;
  assign mem_we = rst_n && (state_q == StWdone) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!mask_q[0]) mem[idx_q][7:0]  <= din_q[7:0];
      if (!mask_q[1]) mem[idx_q][15:8] <= din_q[15:8];
    end
    mem_q <= mem[rd_idx];
  end

  assign ba_ack    = ack_q;
  assign ba_dst    = dst_q;
  assign ba_dok    = dok_q;
  assign ba_rdy    = rdy_q;
  assign data_read = data_read_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jtsdram_bank_resp.sv
module tb_jtsdram_bank_resp;

  localparam int unsigned AW         = 22;
  localparam int unsigned MW         = 10;
  localparam int unsigned CL         = 2;
  localparam int unsigned REF_PERIOD = 384;
  localparam int unsigned REF_LEN    = 8;
  localparam int unsigned Depth      = 1 << MW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ba_addr;
  logic          ba_rd;
  logic          ba_wr;
  logic [15:0]   ba_din;
  logic [1:0]    ba_din_m;
  logic          refresh_en;
  logic          ba_ack;
  logic          ba_dst;
  logic          ba_dok;
  logic          ba_rdy;
  logic [31:0]   data_read;
  logic          busy;

  always #5 clk = ~clk;

  jtsdram_bank_resp #(
    .AW(AW), .MW(MW), .CL(CL), .REF_PERIOD(REF_PERIOD), .REF_LEN(REF_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ba_addr   (ba_addr),
    .ba_rd     (ba_rd),
    .ba_wr     (ba_wr),
    .ba_din    (ba_din),
    .ba_din_m  (ba_din_m),
    .refresh_en(refresh_en),
    .ba_ack    (ba_ack),
    .ba_dst    (ba_dst),
    .ba_dok    (ba_dok),
    .ba_rdy    (ba_rdy),
    .data_read (data_read),
    .busy      (busy)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] model_mem [Depth];
  logic [31:0] last_read;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Flag order: {ack, dst, dok, rdy, busy}
  task automatic chk_f(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, ba_ack, ba_dst, ba_dok, ba_rdy, busy}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
    int unsigned i0;
    int unsigned i1;
    i0 = int'(a[MW-1:0]);
    i1 = (i0 + 1) % Depth;
    return {model_mem[i1], model_mem[i0]};
  endfunction

  // Called in an idle cycle; returns in the first idle cycle after the write.
  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    int unsigned i;
    ba_addr  = a;
    ba_din   = d;
    ba_din_m = m;
    ba_wr    = 1'b1;
    step();
    chk_f("wr_ack", 5'b10001);
    ba_wr    = 1'b0;
    ba_din   = 16'($urandom);
    ba_din_m = 2'($urandom);
    ba_addr  = AW'($urandom);
    i = int'(a[MW-1:0]);
    if (!m[0]) model_mem[i][7:0]  = d[7:0];
    if (!m[1]) model_mem[i][15:8] = d[15:8];
    step();
    chk_f("wr_rdy", 5'b00011);
    chk("wr_hold", data_read, last_read);
    step();
    chk_f("wr_idle", 5'b00000);
    chk("wr_hold2", data_read, last_read);
  endtask

  // Cycles after the ack cycle of a read.
  task automatic read_tail(input logic [31:0] exp);
    for (int c = 2; c <= int'(CL); c++) begin
      step();
      chk_f("rd_wait", 5'b00001);
    end
    step();
    chk_f("rd_dst", 5'b01101);
    step();
    chk_f("rd_dok", 5'b00101);
    step();
    chk_f("rd_rdy", 5'b00011);
    chk("rd_data", data_read, exp);
    last_read = exp;
    step();
    chk_f("rd_idle", 5'b00000);
    chk("rd_hold", data_read, exp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp);
    ba_addr = a;
    ba_rd   = 1'b1;
    step();
    chk_f("rd_ack", 5'b10001);
    ba_rd   = 1'b0;
    ba_addr = AW'($urandom);
    read_tail(exp);
  endtask

  initial begin
    logic [AW-1:0] a;

    // Reset
    rst_n      = 1'b0;
    ba_addr    = '0;
    ba_rd      = 1'b0;
    ba_wr      = 1'b0;
    ba_din     = '0;
    ba_din_m   = '0;
    refresh_en = 1'b0;
    last_read  = '0;
    repeat (3) step();
    chk_f("rst_flags", 5'b00000);
    chk("rst_data", data_read, 32'h0);
    rst_n = 1'b1;
    step();
    chk_f("post_rst_idle", 5'b00000);

    // Basic write then read with two-word result
    do_write(22'h005, 16'h1234, 2'b00);
    do_write(22'h006, 16'hABCD, 2'b00);
    do_read(22'h005, 32'hABCD1234);

    // Byte mask: high byte kept
    do_write(22'h011, 16'h0000, 2'b00);
    do_write(22'h010, 16'hFFFF, 2'b00);
    do_write(22'h010, 16'h0055, 2'b10);
    do_read(22'h010, 32'h0000FF55);
    do_write(22'h010, 16'hAA00, 2'b01);
    do_read(22'h010, 32'h0000AA55);

    // Index wrap and ignored upper address bits
    do_write(22'h3FF, 16'h1111, 2'b00);
    do_write(22'h000, 16'h2222, 2'b00);
    do_read(22'h0003FF, 32'h22221111);
    do_read(22'h3FFFFF, 32'h22221111);

    // Simultaneous read and write: write first, read on a later idle cycle
    do_write(22'h021, 16'h0F0F, 2'b00);
    ba_addr  = 22'h020;
    ba_din   = 16'h5A5A;
    ba_din_m = 2'b00;
    ba_wr    = 1'b1;
    ba_rd    = 1'b1;
    step();
    chk_f("rw_ack", 5'b10001);
    ba_wr = 1'b0;
    model_mem[32] = 16'h5A5A;
    step();
    chk_f("rw_rdy", 5'b00011);
    step();
    chk_f("rw_gap", 5'b00000);
    do_read(22'h020, 32'h0F0F5A5A);

    // Refresh: read raised on the cycle the refresh request becomes pending
    refresh_en = 1'b1;
    repeat (REF_PERIOD) step();
    chk_f("ref_pre", 5'b00000);
    ba_addr = 22'h005;
    ba_rd   = 1'b1;
    for (int i = 0; i < int'(REF_LEN); i++) begin
      step();
      chk_f("ref_stall", 5'b00001);
    end
    step();
    chk_f("ref_gap", 5'b00000);
    step();
    chk_f("ref_ack", 5'b10001);
    ba_rd = 1'b0;
    read_tail(32'hABCD1234);
    refresh_en = 1'b0;

    // Reset during WAIT of a read
    do_write(22'h100, 16'hC0DE, 2'b00);
    do_write(22'h101, 16'hBEEF, 2'b00);
    ba_addr = 22'h100;
    ba_rd   = 1'b1;
    step();
    chk_f("ra_ack", 5'b10001);
    ba_rd = 1'b0;
    step();
    chk_f("ra_wait", 5'b00001);
    rst_n = 1'b0;
    step();
    chk_f("ra_rst_flags", 5'b00000);
    chk("ra_rst_data", data_read, 32'h0);
    rst_n     = 1'b1;
    last_read = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_f("ra_no_rdy", 5'b00000);
    end
    do_read(22'h100, 32'hBEEFC0DE);

    // Randomized: fill the whole store, then mixed traffic with refresh off
    for (int i = 0; i < int'(Depth); i++) begin
      a = AW'($urandom);
      a[MW-1:0] = MW'(i);
      do_write(a, 16'($urandom), 2'b00);
    end
    for (int n = 0; n < 200; n++) begin
      a = AW'($urandom);
      if ($urandom_range(1, 0) == 1) do_write(a, 16'($urandom), 2'($urandom));
      else do_read(a, model_rd(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
